// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: aluSelect load/store codes, datapath widths and store-buffer types.
package riscv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned XBYTES    = XLEN / 8;
   localparam int unsigned ALU_SEL_W = 6;

   localparam logic [ALU_SEL_W-1:0] ALU_LB  = 6'b001011;
   localparam logic [ALU_SEL_W-1:0] ALU_LH  = 6'b001100;
   localparam logic [ALU_SEL_W-1:0] ALU_LW  = 6'b001101;
   localparam logic [ALU_SEL_W-1:0] ALU_LBU = 6'b001110;
   localparam logic [ALU_SEL_W-1:0] ALU_LHU = 6'b001111;
   localparam logic [ALU_SEL_W-1:0] ALU_SB  = 6'b010000;
   localparam logic [ALU_SEL_W-1:0] ALU_SH  = 6'b010001;
   localparam logic [ALU_SEL_W-1:0] ALU_SW  = 6'b010010;

   // Lane-formatted store payload as held in the buffer and presented to memory
   typedef struct packed {
      logic [XLEN-1:0]   wdata;
      logic [XBYTES-1:0] wmask;
   } swb_lane_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } swb_state_e;

   function automatic logic is_store_code(input logic [ALU_SEL_W-1:0] sel);
      return (sel == ALU_SB) || (sel == ALU_SH) || (sel == ALU_SW);
   endfunction

endpackage

// File: rtl/store_lane_formatter.sv
// Combinational SB/SH/SW formatter: replicates store data across byte lanes and builds the byte mask.
module store_lane_formatter
   import riscv_pkg::*;
(
   input  logic [ALU_SEL_W-1:0] i_alu_sel,
   input  logic [1:0]           i_addr_lo,
   input  logic [XLEN-1:0]      i_data,
   output logic                 o_is_store_c,
   output logic                 o_misaligned_c,
   output swb_lane_t            o_lane_c
);

   always_comb begin
      o_is_store_c   = is_store_code(i_alu_sel);
      o_misaligned_c = 1'b0;
      o_lane_c       = '0;
      case (i_alu_sel)
         ALU_SB: begin
            o_lane_c.wdata = {4{i_data[7:0]}};
            o_lane_c.wmask = 4'(4'b0001 << i_addr_lo);
         end
         ALU_SH: begin
            o_lane_c.wdata = {2{i_data[15:0]}};
            o_lane_c.wmask = 4'(4'b0011 << i_addr_lo);
            o_misaligned_c = i_addr_lo[0];
         end
         ALU_SW: begin
            o_lane_c.wdata = i_data;
            o_lane_c.wmask = 4'b1111;
            o_misaligned_c = (i_addr_lo != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/store_write_buffer.sv
// In-order store write buffer draining formatted stores to data memory over req/ack.
// Optional STORE_HAZARD_EN adds the load-vs-buffered-store same-word stall comparators.
module store_write_buffer
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 st_valid,
   output logic                 st_ready,
   input  logic [ALU_SEL_W-1:0] aluSelect,
   input  logic [ADDR_W-1:0]    st_addr,
   input  logic [XLEN-1:0]      st_data,
   output logic                 misaligned,
   output logic                 sb_empty,
   output logic                 mem_req,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [XLEN-1:0]      mem_wdata,
   output logic [XBYTES-1:0]    mem_wmask,
   input  logic                 mem_ack,
   input  logic [ADDR_W-1:0]    ld_addr,
   output logic                 ld_stall
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   swb_state_e        r_state;
   swb_state_e        w_state_nxt;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  w_rd_ptr_inc;
   logic [PTR_W-1:0]  w_load_sel;
   logic [CNT_W-1:0]  r_count;
   logic              r_misaligned;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [XLEN-1:0]   r_mem_wdata;
   logic [XBYTES-1:0] r_mem_wmask;

   logic [ADDR_W-1:2] r_waddr_q [DEPTH];
   swb_lane_t         r_lane_q  [DEPTH];

   logic              w_is_store;
   logic              w_fmt_misaligned;
   swb_lane_t         w_lane;
   logic              w_full;
   logic              w_accept;
   logic              w_enq;
   logic              w_pop;
   logic              w_load_head;
   logic              w_ld_stall;
   logic              w_unused_ld;

   store_lane_formatter u_fmt (
      .i_alu_sel      (aluSelect),
      .i_addr_lo      (st_addr[1:0]),
      .i_data         (st_data),
      .o_is_store_c   (w_is_store),
      .o_misaligned_c (w_fmt_misaligned),
      .o_lane_c       (w_lane)
   );

   // A full buffer refuses even if the head pops in the same cycle
   assign w_full       = (r_count == CNT_W'(DEPTH));
   assign w_accept     = st_valid && !w_full;
   assign w_enq        = w_accept && w_is_store && !w_fmt_misaligned;
   assign w_pop        = (r_state == S_REQ) && mem_ack;
   assign w_rd_ptr_inc = PTR_W'(r_rd_ptr + 1'b1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus which entry (if any) to latch onto the memory request bus
   always_comb begin
      w_state_nxt = r_state;
      w_load_head = 1'b0;
      w_load_sel  = r_rd_ptr;
      unique case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_state_nxt = S_REQ;
               w_load_head = 1'b1;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               if (r_count > CNT_W'(1)) begin
                  w_load_head = 1'b1;
                  w_load_sel  = w_rd_ptr_inc;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_misaligned <= 1'b0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
         r_count      <= CNT_W'(r_count + CNT_W'(w_enq) - CNT_W'(w_pop));
         r_misaligned <= w_accept && w_is_store && w_fmt_misaligned;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wmask <= '0;
      end else if (w_load_head) begin
         r_mem_addr  <= {r_waddr_q[w_load_sel], 2'b00};
         r_mem_wdata <= r_lane_q[w_load_sel].wdata;
         r_mem_wmask <= r_lane_q[w_load_sel].wmask;
      end
   end

   // Entry storage carries no reset; validity is tracked solely by r_count
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_waddr_q[r_wr_ptr] <= st_addr[ADDR_W-1:2];
         r_lane_q[r_wr_ptr]  <= w_lane;
      end
   end

`ifdef STORE_HAZARD_EN
   always_comb begin
      w_ld_stall = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(PTR_W'(PTR_W'(i) - r_rd_ptr)) < r_count) &&
             (r_waddr_q[i] == ld_addr[ADDR_W-1:2])) begin
            w_ld_stall = 1'b1;
         end
      end
   end
   assign w_unused_ld = ^ld_addr[1:0];
`else
   assign w_ld_stall  = 1'b0;
   assign w_unused_ld = ^ld_addr;
`endif

   assign st_ready   = !w_full;
   assign mem_req    = (r_state == S_REQ);
   assign sb_empty   = (r_count == '0) && !mem_req;
   assign misaligned = r_misaligned;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign mem_wmask  = r_mem_wmask;
   assign ld_stall   = w_ld_stall;

endmodule
